// File: rtl/fibo_seq_checker.sv
// Fibonacci stream monitor: locks on the 0,1 seed pair, then checks each term
// against the modular sum of the previous two, flagging mismatch/wrap/period.
module fibo_seq_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] fibo_in,
  output logic             locked,
  output logic [WIDTH-1:0] expected,
  output logic             mismatch,
  output logic             wrap,
  output logic             period_done,
  output logic [CNT_W-1:0] term_count,
  output logic [CNT_W-1:0] err_count,
  output logic             error_sticky
);

  typedef enum logic [1:0] {IDLE, GOT0, TRACK, FAIL} state_t;

  localparam logic [WIDTH-1:0] TERM_ZERO = '0;
  localparam logic [WIDTH-1:0] TERM_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_SEED  = {{(CNT_W-2){1'b0}}, 2'b10};

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_prev1, r_prev2, w_prev1_n, w_prev2_n;
  logic [CNT_W-1:0] r_term_cnt, r_err_cnt, w_term_cnt_n, w_err_cnt_n;
  logic             r_sticky, w_sticky_n;
  logic             r_mismatch, w_mismatch_n;
  logic             r_wrap, w_wrap_n;
  logic             r_period, w_period_n;
  logic             r_locked, w_locked_n;
  logic [WIDTH-1:0] r_expected, w_expected_n;
  logic [WIDTH:0]   w_sum, w_sum_n;

  // Current sum checks the incoming term; next-state sum feeds the registered expected output.
  assign w_sum   = {1'b0, r_prev2}   + {1'b0, r_prev1};
  assign w_sum_n = {1'b0, w_prev2_n} + {1'b0, w_prev1_n};

  always_comb begin
    w_state_n    = r_state;
    w_prev1_n    = r_prev1;
    w_prev2_n    = r_prev2;
    w_term_cnt_n = r_term_cnt;
    w_err_cnt_n  = r_err_cnt;
    w_sticky_n   = r_sticky;
    w_mismatch_n = 1'b0;
    w_wrap_n     = 1'b0;
    w_period_n   = 1'b0;
    if (valid_in) begin
      unique case (r_state)
        IDLE: begin
          if (fibo_in == TERM_ZERO) w_state_n = GOT0;
        end
        GOT0: begin
          if (fibo_in == TERM_ONE) begin
            w_state_n    = TRACK;
            w_prev2_n    = TERM_ZERO;
            w_prev1_n    = TERM_ONE;
            w_term_cnt_n = CNT_SEED;
          end else if (fibo_in != TERM_ZERO) begin
            w_state_n = IDLE;
          end
        end
        TRACK: begin
          if (fibo_in == w_sum[WIDTH-1:0]) begin
            w_prev2_n    = r_prev1;
            w_prev1_n    = fibo_in;
            w_term_cnt_n = (r_term_cnt == CNT_MAX) ? CNT_MAX : r_term_cnt + CNT_ONE;
            w_wrap_n     = w_sum[WIDTH];
            w_period_n   = (r_prev1 == TERM_ZERO) && (fibo_in == TERM_ONE);
          end else begin
            w_state_n    = FAIL;
            w_mismatch_n = 1'b1;
            w_err_cnt_n  = (r_err_cnt == CNT_MAX) ? CNT_MAX : r_err_cnt + CNT_ONE;
            w_sticky_n   = 1'b1;
          end
        end
        FAIL: begin
          if (fibo_in == TERM_ZERO) w_state_n = GOT0;
        end
        default: w_state_n = IDLE;
      endcase
    end
    w_locked_n   = (w_state_n == TRACK);
    w_expected_n = w_locked_n ? w_sum_n[WIDTH-1:0] : TERM_ZERO;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prev1    <= '0;
      r_prev2    <= '0;
      r_term_cnt <= '0;
      r_err_cnt  <= '0;
      r_sticky   <= 1'b0;
      r_mismatch <= 1'b0;
      r_wrap     <= 1'b0;
      r_period   <= 1'b0;
      r_locked   <= 1'b0;
      r_expected <= '0;
    end else begin
      r_state    <= w_state_n;
      r_prev1    <= w_prev1_n;
      r_prev2    <= w_prev2_n;
      r_term_cnt <= w_term_cnt_n;
      r_err_cnt  <= w_err_cnt_n;
      r_sticky   <= w_sticky_n;
      r_mismatch <= w_mismatch_n;
      r_wrap     <= w_wrap_n;
      r_period   <= w_period_n;
      r_locked   <= w_locked_n;
      r_expected <= w_expected_n;
    end
  end

  assign locked       = r_locked;
  assign expected     = r_expected;
  assign mismatch     = r_mismatch;
  assign wrap         = r_wrap;
  assign period_done  = r_period;
  assign term_count   = r_term_cnt;
  assign err_count    = r_err_cnt;
  assign error_sticky = r_sticky;

endmodule

// File: tb/tb_fibo_seq_checker.sv
// Bench for fibo_seq_checker: integer reference model checked every cycle,
// plus directed literal expectations for lock, wrap, period, mismatch and reset.
module tb_fibo_seq_checker;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int MOD   = 16;
  localparam int CMAX  = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_in;
  logic [WIDTH-1:0] fibo_in;
  logic             locked;
  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             wrap;
  logic             period_done;
  logic [CNT_W-1:0] term_count;
  logic [CNT_W-1:0] err_count;
  logic             error_sticky;

  fibo_seq_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .fibo_in(fibo_in),
    .locked(locked), .expected(expected), .mismatch(mismatch), .wrap(wrap),
    .period_done(period_done), .term_count(term_count), .err_count(err_count),
    .error_sticky(error_sticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase 0=waiting for 0, 1=seen 0, 2=tracking, 3=failed; a=older term, b=newer term
  int m_phase = 0, m_a = 0, m_b = 0, m_tc = 0, m_ec = 0;
  int m_sticky = 0, m_mis = 0, m_wrap = 0, m_pd = 0;
  bit chk_en = 1'b0;

  // Fibonacci mod 16, one Pisano period, written out by hand
  int fib16[24] = '{0,1,1,2,3,5,8,13,5,2,7,9,0,9,9,2,11,13,8,5,13,2,15,1};

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit v, input int t);
    if (r) begin
      m_phase = 0; m_a = 0; m_b = 0; m_tc = 0; m_ec = 0;
      m_sticky = 0; m_mis = 0; m_wrap = 0; m_pd = 0;
      return;
    end
    m_mis = 0; m_wrap = 0; m_pd = 0;
    if (!v) return;
    if (m_phase == 0) begin
      if (t == 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (t == 1) begin m_phase = 2; m_a = 0; m_b = 1; m_tc = 2; end
      else if (t != 0) m_phase = 0;
    end else if (m_phase == 2) begin
      if (t == (m_a + m_b) % MOD) begin
        m_wrap = (m_a + m_b >= MOD) ? 1 : 0;
        m_pd   = (m_b == 0 && t == 1) ? 1 : 0;
        m_a = m_b; m_b = t;
        m_tc = (m_tc + 1 > CMAX) ? CMAX : m_tc + 1;
      end else begin
        m_mis = 1; m_sticky = 1; m_phase = 3;
        m_ec = (m_ec + 1 > CMAX) ? CMAX : m_ec + 1;
      end
    end else begin
      if (t == 0) m_phase = 1;
    end
  endtask

  task automatic step(input bit r, input bit v, input int t);
    reset    = r;
    valid_in = v;
    fibo_in  = WIDTH'(t);
    @(posedge clk);
    model_update(r, v, t);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("locked",       int'(locked),       (m_phase == 2) ? 1 : 0);
      check("expected",     int'(expected),     (m_phase == 2) ? (m_a + m_b) % MOD : 0);
      check("mismatch",     int'(mismatch),     m_mis);
      check("wrap",         int'(wrap),         m_wrap);
      check("period_done",  int'(period_done),  m_pd);
      check("term_count",   int'(term_count),   m_tc);
      check("err_count",    int'(err_count),    m_ec);
      check("error_sticky", int'(error_sticky), m_sticky);
    end
  end

  initial begin
    int wraps, pd_hits, pd_other;
    int mseq[5] = '{0,1,1,2,3};
    int gseq[5] = '{0,0,1,1,2};
    wraps = 0; pd_hits = 0; pd_other = 0;
    reset = 1'b1; valid_in = 1'b0; fibo_in = '0;

    step(1, 0, 0);
    chk_en = 1'b1;
    step(1, 1, 7);
    check("rst_locked", int'(locked), 0);
    check("rst_tc", int'(term_count), 0);
    check("rst_exp", int'(expected), 0);
    check("rst_sticky", int'(error_sticky), 0);

    // Lock, track, wrap and period over 60 terms
    for (int i = 0; i < 60; i++) begin
      step(0, 1, fib16[i % 24]);
      if (i == 0) check("no_lock_1st", int'(locked), 0);
      if (i == 1) begin
        check("lock_after_2nd", int'(locked), 1);
        check("exp_after_seed", int'(expected), 1);
      end
      if (i == 8)  check("wrap_term8", int'(wrap), 1);
      if (i == 10) check("tc_11", int'(term_count), 11);
      if (wrap === 1'b1) wraps++;
      if (period_done === 1'b1) begin
        if (i == 25 || i == 49) pd_hits++;
        else pd_other++;
      end
    end
    check("tc_60", int'(term_count), 60);
    check("ec_60", int'(err_count), 0);
    check("wrap_count", wraps, 20);
    check("pd_hits", pd_hits, 2);
    check("pd_other", pd_other, 0);

    // Mismatch, silent FAIL, relock
    step(1, 0, 0);
    foreach (mseq[k]) step(0, 1, mseq[k]);
    step(0, 1, 6);
    check("mis_pulse", int'(mismatch), 1);
    check("mis_ec", int'(err_count), 1);
    check("mis_sticky", int'(error_sticky), 1);
    check("mis_locked", int'(locked), 0);
    check("mis_tc_hold", int'(term_count), 5);
    check("mis_exp", int'(expected), 0);
    step(0, 1, 4);
    check("fail_silent1", int'(mismatch), 0);
    step(0, 1, 7);
    check("fail_silent2", int'(mismatch), 0);
    check("fail_locked", int'(locked), 0);
    check("fail_ec", int'(err_count), 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    check("relock", int'(locked), 1);
    check("relock_tc", int'(term_count), 3);
    check("relock_sticky", int'(error_sticky), 1);

    // Reset mid-sequence at the term 13
    step(0, 1, 2);
    step(0, 1, 3);
    step(0, 1, 5);
    step(0, 1, 8);
    step(1, 1, 13);
    check("midrst_locked", int'(locked), 0);
    check("midrst_tc", int'(term_count), 0);
    check("midrst_ec", int'(err_count), 0);
    check("midrst_sticky", int'(error_sticky), 0);
    check("midrst_exp", int'(expected), 0);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    check("postrst_lock", int'(locked), 1);
    check("postrst_tc", int'(term_count), 3);

    // Valid gaps with a repeated seed zero
    step(1, 0, 0);
    foreach (gseq[k]) begin
      step(0, 1, gseq[k]);
      if (k == 2) check("gap_lock", int'(locked), 1);
      for (int g = 0; g < 3; g++) step(0, 0, 9 + g);
      if (k == 1) check("gap_nolock", int'(locked), 0);
    end
    check("gap_tc", int'(term_count), 4);
    check("gap_ec", int'(err_count), 0);
    check("gap_exp", int'(expected), 3);

    // 0 then 5 drops back to IDLE, so a following 1 must not lock
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 5);
    step(0, 1, 1);
    check("idle_no_lock", int'(locked), 0);
    step(0, 0, 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
